// File: rtl/commit_ctrl.sv
// commit_ctrl: dual-slot commit controller with GPR/CSR write ports, flushes, CSR serialisation and IDLE wait
module commit_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  commit_valid,
    input  logic [1:0]  reg_we_i,
    input  logic [4:0]  reg_waddr1_i,
    input  logic [4:0]  reg_waddr2_i,
    input  logic [31:0] reg_wdata1_i,
    input  logic [31:0] reg_wdata2_i,
    input  logic [1:0]  csr_we_i,
    input  logic [13:0] csr_addr1_i,
    input  logic [13:0] csr_addr2_i,
    input  logic [31:0] csr_wdata1_i,
    input  logic [31:0] csr_wdata2_i,
    input  logic [1:0]  is_llw_scw_i,
    input  logic [5:0]  is_exception1_i,
    input  logic [5:0]  is_exception2_i,
    input  logic [6:0]  exception_cause1_i,
    input  logic [6:0]  exception_cause2_i,
    input  logic [31:0] pc1_i,
    input  logic [31:0] pc2_i,
    input  logic [1:0]  idle_i,
    input  logic [1:0]  ertn_i,
    input  logic        int_pending_i,
    output logic [1:0]  reg_we_o,
    output logic [4:0]  reg_waddr1_o,
    output logic [4:0]  reg_waddr2_o,
    output logic [31:0] reg_wdata1_o,
    output logic [31:0] reg_wdata2_o,
    output logic        csr_we_o,
    output logic [13:0] csr_addr_o,
    output logic [31:0] csr_wdata_o,
    output logic [1:0]  llw_scw_o,
    output logic        excp_flush_o,
    output logic [31:0] excp_pc_o,
    output logic [6:0]  excp_cause_o,
    output logic        ertn_flush_o,
    output logic        idle_o,
    output logic        stall_o
);
    typedef enum logic [1:0] {RUN, CSR2, IDLE} state_t;
    state_t      state_q, state_d;
    logic [1:0]  reg_we_q, reg_we_d;
    logic [4:0]  reg_waddr1_q, reg_waddr1_d, reg_waddr2_q, reg_waddr2_d;
    logic [31:0] reg_wdata1_q, reg_wdata1_d, reg_wdata2_q, reg_wdata2_d;
    logic        csr_we_q, csr_we_d;
    logic [13:0] csr_addr_q, csr_addr_d, lat_addr_q, lat_addr_d;
    logic [31:0] csr_wdata_q, csr_wdata_d, lat_wdata_q, lat_wdata_d;
    logic [1:0]  llw_scw_q, llw_scw_d;
    logic        excp_flush_q, excp_flush_d, ertn_flush_q, ertn_flush_d;
    logic [31:0] excp_pc_q, excp_pc_d;
    logic [6:0]  excp_cause_q, excp_cause_d;
    logic        idle_pend_q, idle_pend_d;
    logic        x1, e1, ok2, x2, e2, w1, w2, c1, c2, go_idle;

    // Slot kill chain: slot2 only retires behind a retiring slot1 with no ertn/idle
    assign x1      = commit_valid[0] & (|is_exception1_i);
    assign e1      = commit_valid[0] & ~(|is_exception1_i);
    assign ok2     = e1 & ~ertn_i[0] & ~idle_i[0];
    assign x2      = commit_valid[1] & (|is_exception2_i) & ok2;
    assign e2      = commit_valid[1] & ~(|is_exception2_i) & ok2;
    assign w2      = e2 & reg_we_i[1] & (reg_waddr2_i != 5'd0);
    assign w1      = e1 & reg_we_i[0] & (reg_waddr1_i != 5'd0) & ~(w2 & (reg_waddr1_i == reg_waddr2_i));
    assign c1      = e1 & csr_we_i[0];
    assign c2      = e2 & csr_we_i[1];
    assign go_idle = (e1 & idle_i[0]) | (e2 & idle_i[1]);

    // Next-state and next-output decode; outputs default to 0 every cycle
    always_comb begin
        state_d      = state_q;
        lat_addr_d   = lat_addr_q;
        lat_wdata_d  = lat_wdata_q;
        idle_pend_d  = idle_pend_q;
        reg_we_d     = '0;
        reg_waddr1_d = '0;
        reg_waddr2_d = '0;
        reg_wdata1_d = '0;
        reg_wdata2_d = '0;
        csr_we_d     = 1'b0;
        csr_addr_d   = '0;
        csr_wdata_d  = '0;
        llw_scw_d    = '0;
        excp_flush_d = 1'b0;
        excp_pc_d    = '0;
        excp_cause_d = '0;
        ertn_flush_d = 1'b0;
        if (state_q == RUN) begin
            reg_we_d     = {w2, w1};
            reg_waddr1_d = e1 ? reg_waddr1_i : 5'd0;
            reg_wdata1_d = e1 ? reg_wdata1_i : 32'd0;
            reg_waddr2_d = e2 ? reg_waddr2_i : 5'd0;
            reg_wdata2_d = e2 ? reg_wdata2_i : 32'd0;
            csr_we_d     = c1 | c2;
            csr_addr_d   = c1 ? csr_addr1_i : (c2 ? csr_addr2_i : 14'd0);
            csr_wdata_d  = c1 ? csr_wdata1_i : (c2 ? csr_wdata2_i : 32'd0);
            llw_scw_d    = {e2 & is_llw_scw_i[1], e1 & is_llw_scw_i[0]};
            excp_flush_d = x1 | x2;
            excp_pc_d    = x1 ? pc1_i : (x2 ? pc2_i : 32'd0);
            excp_cause_d = x1 ? exception_cause1_i : (x2 ? exception_cause2_i : 7'd0);
            ertn_flush_d = (e1 & ertn_i[0]) | (e2 & ertn_i[1]);
            if (c1 & c2) begin
                lat_addr_d  = csr_addr2_i;
                lat_wdata_d = csr_wdata2_i;
                idle_pend_d = go_idle;
                state_d     = CSR2;
            end else if (go_idle) begin
                state_d = IDLE;
            end
        end else if (state_q == CSR2) begin
            csr_we_d    = 1'b1;
            csr_addr_d  = lat_addr_q;
            csr_wdata_d = lat_wdata_q;
            lat_addr_d  = '0;
            lat_wdata_d = '0;
            idle_pend_d = 1'b0;
            state_d     = idle_pend_q ? IDLE : RUN;
        end else begin
            state_d = int_pending_i ? RUN : IDLE;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= RUN;
            lat_addr_q   <= '0;
            lat_wdata_q  <= '0;
            idle_pend_q  <= 1'b0;
            reg_we_q     <= '0;
            reg_waddr1_q <= '0;
            reg_waddr2_q <= '0;
            reg_wdata1_q <= '0;
            reg_wdata2_q <= '0;
            csr_we_q     <= 1'b0;
            csr_addr_q   <= '0;
            csr_wdata_q  <= '0;
            llw_scw_q    <= '0;
            excp_flush_q <= 1'b0;
            excp_pc_q    <= '0;
            excp_cause_q <= '0;
            ertn_flush_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lat_addr_q   <= lat_addr_d;
            lat_wdata_q  <= lat_wdata_d;
            idle_pend_q  <= idle_pend_d;
            reg_we_q     <= reg_we_d;
            reg_waddr1_q <= reg_waddr1_d;
            reg_waddr2_q <= reg_waddr2_d;
            reg_wdata1_q <= reg_wdata1_d;
            reg_wdata2_q <= reg_wdata2_d;
            csr_we_q     <= csr_we_d;
            csr_addr_q   <= csr_addr_d;
            csr_wdata_q  <= csr_wdata_d;
            llw_scw_q    <= llw_scw_d;
            excp_flush_q <= excp_flush_d;
            excp_pc_q    <= excp_pc_d;
            excp_cause_q <= excp_cause_d;
            ertn_flush_q <= ertn_flush_d;
        end
    end

    assign reg_we_o     = reg_we_q;
    assign reg_waddr1_o = reg_waddr1_q;
    assign reg_waddr2_o = reg_waddr2_q;
    assign reg_wdata1_o = reg_wdata1_q;
    assign reg_wdata2_o = reg_wdata2_q;
    assign csr_we_o     = csr_we_q;
    assign csr_addr_o   = csr_addr_q;
    assign csr_wdata_o  = csr_wdata_q;
    assign llw_scw_o    = llw_scw_q;
    assign excp_flush_o = excp_flush_q;
    assign excp_pc_o    = excp_pc_q;
    assign excp_cause_o = excp_cause_q;
    assign ertn_flush_o = ertn_flush_q;
    assign stall_o      = (state_q != RUN);
    assign idle_o       = (state_q == IDLE);
endmodule

// File: tb/tb_commit_ctrl.sv
// tb_commit_ctrl: directed-vector bench for commit_ctrl
module tb_commit_ctrl;
    logic        clk = 0, rst = 0;
    logic [1:0]  commit_valid, reg_we_i, csr_we_i, is_llw_scw_i, idle_i, ertn_i;
    logic [4:0]  reg_waddr1_i, reg_waddr2_i;
    logic [31:0] reg_wdata1_i, reg_wdata2_i, csr_wdata1_i, csr_wdata2_i, pc1_i, pc2_i;
    logic [13:0] csr_addr1_i, csr_addr2_i;
    logic [5:0]  is_exception1_i, is_exception2_i;
    logic [6:0]  exception_cause1_i, exception_cause2_i;
    logic        int_pending_i;
    logic [1:0]  reg_we_o, llw_scw_o;
    logic [4:0]  reg_waddr1_o, reg_waddr2_o;
    logic [31:0] reg_wdata1_o, reg_wdata2_o, csr_wdata_o, excp_pc_o;
    logic        csr_we_o, excp_flush_o, ertn_flush_o, idle_o, stall_o;
    logic [13:0] csr_addr_o;
    logic [6:0]  excp_cause_o;
    int vectors = 0, miscompares = 0;

    commit_ctrl dut (
        .clk(clk), .rst(rst), .commit_valid(commit_valid), .reg_we_i(reg_we_i),
        .reg_waddr1_i(reg_waddr1_i), .reg_waddr2_i(reg_waddr2_i),
        .reg_wdata1_i(reg_wdata1_i), .reg_wdata2_i(reg_wdata2_i),
        .csr_we_i(csr_we_i), .csr_addr1_i(csr_addr1_i), .csr_addr2_i(csr_addr2_i),
        .csr_wdata1_i(csr_wdata1_i), .csr_wdata2_i(csr_wdata2_i),
        .is_llw_scw_i(is_llw_scw_i), .is_exception1_i(is_exception1_i),
        .is_exception2_i(is_exception2_i), .exception_cause1_i(exception_cause1_i),
        .exception_cause2_i(exception_cause2_i), .pc1_i(pc1_i), .pc2_i(pc2_i),
        .idle_i(idle_i), .ertn_i(ertn_i), .int_pending_i(int_pending_i),
        .reg_we_o(reg_we_o), .reg_waddr1_o(reg_waddr1_o), .reg_waddr2_o(reg_waddr2_o),
        .reg_wdata1_o(reg_wdata1_o), .reg_wdata2_o(reg_wdata2_o),
        .csr_we_o(csr_we_o), .csr_addr_o(csr_addr_o), .csr_wdata_o(csr_wdata_o),
        .llw_scw_o(llw_scw_o), .excp_flush_o(excp_flush_o), .excp_pc_o(excp_pc_o),
        .excp_cause_o(excp_cause_o), .ertn_flush_o(ertn_flush_o),
        .idle_o(idle_o), .stall_o(stall_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        commit_valid = 0; reg_we_i = 0; csr_we_i = 0; is_llw_scw_i = 0; idle_i = 0; ertn_i = 0;
        reg_waddr1_i = 0; reg_waddr2_i = 0; reg_wdata1_i = 0; reg_wdata2_i = 0;
        csr_addr1_i = 0; csr_addr2_i = 0; csr_wdata1_i = 0; csr_wdata2_i = 0;
        is_exception1_i = 0; is_exception2_i = 0; exception_cause1_i = 0; exception_cause2_i = 0;
        pc1_i = 0; pc2_i = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic dbl_csr();
        clr();
        commit_valid = 2'b11; csr_we_i = 2'b11;
        csr_addr1_i = 14'h0006; csr_wdata1_i = 32'h1;
        csr_addr2_i = 14'h0007; csr_wdata2_i = 32'h2;
    endtask

    initial begin
        clr(); int_pending_i = 0;
        // reset
        step(); step();
        chk("rst_reg_we", reg_we_o, 0);
        chk("rst_csr_we", csr_we_o, 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_idle", idle_o, 0);
        chk("rst_flush", {excp_flush_o, ertn_flush_o}, 0);
        rst = 1;
        // dual GPR
        commit_valid = 2'b11; reg_we_i = 2'b11;
        reg_waddr1_i = 5; reg_wdata1_i = 32'h11; reg_waddr2_i = 6; reg_wdata2_i = 32'h22;
        step();
        chk("dual_we", reg_we_o, 2'b11);
        chk("dual_p1", {reg_waddr1_o, reg_wdata1_o}, {5'd5, 32'h11});
        chk("dual_p2", {reg_waddr2_o, reg_wdata2_o}, {5'd6, 32'h22});
        chk("dual_stall", stall_o, 0);
        // same address: younger wins
        reg_waddr1_i = 7; reg_wdata1_i = 32'hA; reg_waddr2_i = 7; reg_wdata2_i = 32'hB;
        step();
        chk("same_we", reg_we_o, 2'b10);
        chk("same_p2", {reg_waddr2_o, reg_wdata2_o}, {5'd7, 32'hB});
        // write to r0 suppressed
        reg_waddr1_i = 0; reg_waddr2_i = 9;
        step();
        chk("r0_we", reg_we_o, 2'b10);
        // double CSR, inputs held through the stall
        dbl_csr();
        step();
        chk("dcsr1", {csr_we_o, csr_addr_o, csr_wdata_o}, {1'b1, 14'h6, 32'h1});
        chk("dcsr1_stall", stall_o, 1);
        step();
        chk("dcsr2", {csr_we_o, csr_addr_o, csr_wdata_o}, {1'b1, 14'h7, 32'h2});
        chk("dcsr2_stall", stall_o, 0);
        step();
        chk("dcsr_held1", {csr_we_o, csr_addr_o, stall_o}, {1'b1, 14'h6, 1'b1});
        clr();
        step();
        chk("dcsr_held2", {csr_we_o, csr_addr_o, stall_o}, {1'b1, 14'h7, 1'b0});
        step();
        chk("dcsr_quiet", csr_we_o, 0);
        // single CSR writer on slot2
        commit_valid = 2'b11; csr_we_i = 2'b10; csr_addr2_i = 14'h100; csr_wdata2_i = 32'h55;
        step();
        chk("scsr", {csr_we_o, csr_addr_o, csr_wdata_o, stall_o}, {1'b1, 14'h100, 32'h55, 1'b0});
        // slot1 exception kills everything
        clr();
        commit_valid = 2'b11; is_exception1_i = 6'h01; exception_cause1_i = 7'h0B; pc1_i = 32'h1C000100;
        reg_we_i = 2'b10; reg_waddr2_i = 3; reg_wdata2_i = 32'h33;
        step();
        chk("ex1_flush", excp_flush_o, 1);
        chk("ex1_pc", excp_pc_o, 32'h1C000100);
        chk("ex1_cause", excp_cause_o, 7'h0B);
        chk("ex1_we", reg_we_o, 0);
        chk("ex1_stall", stall_o, 0);
        clr();
        step();
        chk("ex1_pulse", excp_flush_o, 0);
        // slot2 exception, slot1 retires
        commit_valid = 2'b11; reg_we_i = 2'b01; reg_waddr1_i = 4; reg_wdata1_i = 32'h44;
        is_exception2_i = 6'h02; exception_cause2_i = 7'h0C; pc2_i = 32'h1C000204;
        step();
        chk("ex2_we", reg_we_o, 2'b01);
        chk("ex2_flush", {excp_flush_o, excp_pc_o, excp_cause_o}, {1'b1, 32'h1C000204, 7'h0C});
        // both except: slot1 wins
        is_exception1_i = 6'h04; exception_cause1_i = 7'h08; pc1_i = 32'h1C000300;
        step();
        chk("ex12", {excp_flush_o, excp_pc_o, excp_cause_o, reg_we_o}, {1'b1, 32'h1C000300, 7'h08, 2'b00});
        // ertn on slot1 kills slot2
        clr();
        commit_valid = 2'b11; ertn_i = 2'b01; reg_we_i = 2'b10; reg_waddr2_i = 3;
        step();
        chk("ertn", {ertn_flush_o, reg_we_o}, {1'b1, 2'b00});
        clr();
        step();
        chk("ertn_pulse", ertn_flush_o, 0);
        // LL/SC masking with slot2 invalid
        commit_valid = 2'b01; is_llw_scw_i = 2'b11;
        step();
        chk("llsc", llw_scw_o, 2'b01);
        // IDLE on slot1
        clr();
        commit_valid = 2'b11; idle_i = 2'b01; reg_we_i = 2'b11; reg_waddr1_i = 8; reg_waddr2_i = 9;
        step();
        chk("idle_we", reg_we_o, 2'b01);
        chk("idle_enter", {idle_o, stall_o}, 2'b11);
        clr();
        step();
        chk("idle_wait", {idle_o, stall_o, reg_we_o}, {2'b11, 2'b00});
        int_pending_i = 1;
        step();
        chk("idle_exit", {idle_o, stall_o}, 2'b00);
        int_pending_i = 0;
        // double CSR with idle on slot2: CSR2 then IDLE, interrupt already pending
        dbl_csr(); idle_i = 2'b10;
        step();
        chk("ci_csr1", {csr_addr_o, stall_o, idle_o}, {14'h6, 2'b10});
        clr(); int_pending_i = 1;
        step();
        chk("ci_csr2", {csr_we_o, csr_addr_o, stall_o, idle_o}, {1'b1, 14'h7, 2'b11});
        step();
        chk("ci_run", {csr_we_o, stall_o, idle_o}, 3'b000);
        int_pending_i = 0;
        // reset during CSR2 drops the latched write
        dbl_csr();
        step();
        chk("rc_stall", stall_o, 1);
        rst = 0;
        step();
        chk("rc_rst", {csr_we_o, csr_addr_o, csr_wdata_o, stall_o, reg_we_o}, 0);
        rst = 1; clr();
        step();
        chk("rc_after", {csr_we_o, stall_o, idle_o}, 3'b000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/commit_ctrl.md
# commit_ctrl

Commit-stage controller for the dual-issue pipeline, fed by the writeback register stage. It decides per cycle which of the two committed slots may retire, and drives the two register-file write ports and the single CSR write port. It serialises double CSR writes over two cycles and raises exception/ertn flushes. It also runs the IDLE wait, stalling writeback via `stall_o` until an interrupt arrives.

## Interface
- No parameters.
- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous reset, active-low (rst=0 resets on next edge)
- commit_valid  in  2  slot valid, bit0 = slot1 (older), bit1 = slot2
- reg_we_i  in  2  per-slot GPR write enable
- reg_waddr1_i / reg_waddr2_i  in  5  GPR write address
- reg_wdata1_i / reg_wdata2_i  in  32  GPR write data
- csr_we_i  in  2  per-slot CSR write enable
- csr_addr1_i / csr_addr2_i  in  14  CSR address
- csr_wdata1_i / csr_wdata2_i  in  32  CSR write data
- is_llw_scw_i  in  2  per-slot LL/SC marker
- is_exception1_i / is_exception2_i  in  6  nonzero = slot carries exception
- exception_cause1_i / exception_cause2_i  in  7  merged cause code
- pc1_i / pc2_i  in  32  slot PC
- idle_i / ertn_i  in  2  per-slot IDLE / ERTN
- int_pending_i  in  1  interrupt pending (from CSR unit)
- reg_we_o  out  2  GPR port enables
- reg_waddr1_o / reg_waddr2_o  out  5; reg_wdata1_o / reg_wdata2_o  out  32
- csr_we_o  out  1; csr_addr_o  out  14; csr_wdata_o  out  32
- llw_scw_o  out  2  masked LL/SC markers
- excp_flush_o  out  1  one-cycle pulse; excp_pc_o  out  32; excp_cause_o  out  7
- ertn_flush_o  out  1  one-cycle pulse
- idle_o  out  1  core idling
- stall_o  out  1  upstream must hold its bundle; block ignores inputs while high

## Operation
- Inputs sampled only in state RUN with stall_o=0.
- Slot kill, priority order: slot1 exception > slot1 ertn > slot1 idle > slot2 exception > slot2 ertn > slot2 idle.
- e1 = commit_valid[0] & is_exception1_i==0. Slot2 may retire only if e1 retires and slot1 has no ertn/idle.
- e2 = commit_valid[1] & is_exception2_i==0 & slot2 may retire.
- An excepting slot retires nothing. Its reg, csr and llw_scw outputs are 0.
- excp_flush_o=1 with that slot's PC and cause. Slot1 wins when both slots except.
- ertn on a retiring slot: ertn_flush_o=1. Later slot killed.
- GPR: reg_we_o[k] = slot k retiring & reg_we_i[k]. Addresses and data pass through.
- Both enabled with the same nonzero address: port1 suppressed (younger wins).
- Any write to address 0 is suppressed.
- CSR: exactly one retiring writer: that write goes to csr_* outputs.
- Both slots retiring with csr_we_i: slot1 written now, slot2 addr/data latched, FSM → CSR2.
- FSM states:
  - RUN: normal retirement.
  - CSR2: stall_o=1. Latched slot2 CSR write issued. → RUN.
  - IDLE: stall_o=1, idle_o=1. int_pending_i=1 → RUN.
- A retiring slot with idle_i → IDLE after its own writes retire.
- Double CSR plus idle on slot2: CSR2 first, then IDLE.
- Flush and state: flush pulses are issued in the RUN decision cycle. FSM stays RUN on any exception.

## Timing
- All outputs registered: bundle sampled in cycle N appears in cycle N+1.
- Write to latched slot2 CSR appears in cycle N+2.
- stall_o is a registered state decode. It is high during the cycle(s) the FSM is in CSR2 or IDLE.
- Reset (rst=0 at an edge), regardless of state:
  - state RUN; all outputs 0.
  - Latched CSR buffer cleared; a pending CSR2 write is dropped.
- int_pending_i already high on IDLE entry: one IDLE cycle, then RUN. Minimum stall is 1 cycle.
- Pulses (excp_flush_o, ertn_flush_o) last exactly one cycle per triggering bundle.

## Test plan
- Dual GPR: both valid, we=11, addr 5/6, data 0x11/0x22 → next cycle reg_we_o=11, 5←0x11, 6←0x22, stall_o=0.
- Same GPR address: both write addr 7 (0xA then 0xB) → reg_we_o=10, only 7←0xB.
- Double CSR: slot1 0x0006←0x1, slot2 0x0007←0x2.
  - Cycle N+1: csr 0x0006/0x1, stall_o=1.
  - Cycle N+2: csr 0x0007/0x2, stall_o=0.
  - Inputs held during stall retire at N+2 sampling.
- Exception on slot1: is_exception1_i=0x01, cause 0x0B, pc1=0x1C000100, slot2 writing GPR 3 → excp_flush_o pulse, excp_pc_o=0x1C000100, excp_cause_o=0x0B, reg_we_o=00.
- IDLE:
  - slot1 idle, slot2 GPR write → slot2 killed; idle_o=1, stall_o=1 while int_pending_i=0.
  - int_pending_i=1 → RUN next cycle, stall_o=0.
- Reset mid-CSR2: rst=0 during CSR2 → all outputs 0, latched write never issued, RUN after rst=1.
